// File: rtl/lock_sequencer.sv
// lock_sequencer: accepts three one-hot digit groups under valid/ready,
// compares them against a stored combination, holds the lock open for a
// bounded time, counts failed attempts and imposes a timed lockout.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_G0      | idle, waiting for the first group of an attempt
// ST_G1      | first group taken, waiting for the second
// ST_G2      | second group taken, waiting for the third
// ST_OPEN    | lock open, hold timer running
// ST_LOCKOUT | too many failures, lockout timer running
module lock_sequencer #(
    parameter logic [39:0] PART0          = 40'h01_0800_2001,
    parameter logic [39:0] PART1          = 40'h00_4010_0401,
    parameter logic [39:0] PART2          = 40'h01_0800_2001,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter int unsigned OPEN_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [39:0] digits_i,
    input  logic        digits_vld_i,
    output logic        entry_rdy_o,
    input  logic        override_i,
    input  logic        relock_i,
    output logic        open_o,
    output logic        locked_out_o,
    output logic [3:0]  fail_cnt_o,
    output logic        bad_digit_o
);

    typedef enum logic [2:0] {
        ST_G0      = 3'd0,
        ST_G1      = 3'd1,
        ST_G2      = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [15:0] OPEN_LOAD    = 16'(OPEN_CYCLES);
    localparam logic [15:0] LOCKOUT_LOAD = 16'(LOCKOUT_CYCLES);
    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES);
    localparam logic [3:0]  MAX_FAILS_C  = 4'(MAX_FAILS);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  fail_q, fail_d;
    logic        match_q, match_d;
    logic        bad_q, bad_d;
    logic        open_q, locked_q, rdy_q;

    logic        accept;
    logic        group_onehot;
    logic        group_ok;
    logic [39:0] part_sel;
    logic [3:0]  fail_inc;

    // Every digit field must carry exactly one set bit.
    function automatic logic digits_onehot(input logic [39:0] g);
        logic       ok;
        logic [9:0] d;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = g[i*10 +: 10];
            if ((d == 10'd0) || ((d & (d - 10'd1)) != 10'd0)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Compare the presented group against the part expected in the current state.
    always_comb begin
        part_sel = PART0;
        case (state_q)
            ST_G1:   part_sel = PART1;
            ST_G2:   part_sel = PART2;
            default: part_sel = PART0;
        endcase
        group_onehot = digits_onehot(digits_i);
        group_ok     = group_onehot && (digits_i == part_sel);
        accept       = digits_vld_i && ((state_q == ST_G0) || (state_q == ST_G1)
                                        || (state_q == ST_G2));
        fail_inc     = fail_q + 4'd1;
    end

    // Next-state logic; override preempts everything, including a same-cycle group.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        match_d = match_q;
        bad_d   = 1'b0;

        if (override_i) begin
            state_d = ST_OPEN;
            timer_d = OPEN_LOAD;
            fail_d  = 4'd0;
            match_d = 1'b1;
        end else begin
            case (state_q)
                ST_G0: begin
                    if (accept) begin
                        match_d = group_ok;
                        bad_d   = ~group_onehot;
                        timer_d = TIMEOUT_LOAD;
                        state_d = ST_G1;
                    end
                end
                ST_G1: begin
                    if (accept) begin
                        match_d = match_q & group_ok;
                        bad_d   = ~group_onehot;
                        timer_d = TIMEOUT_LOAD;
                        state_d = ST_G2;
                    end else if (timer_q <= 16'd1) begin
                        timer_d = 16'd0;
                        state_d = ST_G0;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                ST_G2: begin
                    if (accept) begin
                        bad_d   = ~group_onehot;
                        match_d = 1'b1;
                        if (match_q && group_ok) begin
                            state_d = ST_OPEN;
                            timer_d = OPEN_LOAD;
                            fail_d  = 4'd0;
                        end else if (fail_inc == MAX_FAILS_C) begin
                            state_d = ST_LOCKOUT;
                            timer_d = LOCKOUT_LOAD;
                            fail_d  = fail_inc;
                        end else begin
                            state_d = ST_G0;
                            timer_d = 16'd0;
                            fail_d  = fail_inc;
                        end
                    end else if (timer_q <= 16'd1) begin
                        timer_d = 16'd0;
                        state_d = ST_G0;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                ST_OPEN: begin
                    if (relock_i || (timer_q <= 16'd1)) begin
                        timer_d = 16'd0;
                        state_d = ST_G0;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer_q <= 16'd1) begin
                        timer_d = 16'd0;
                        fail_d  = 4'd0;
                        state_d = ST_G0;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                default: begin
                    state_d = ST_G0;
                    timer_d = 16'd0;
                end
            endcase
        end
    end

    // State, timer and registered outputs, with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_G0;
            timer_q  <= 16'd0;
            fail_q   <= 4'd0;
            match_q  <= 1'b1;
            bad_q    <= 1'b0;
            open_q   <= 1'b0;
            locked_q <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            fail_q   <= fail_d;
            match_q  <= match_d;
            bad_q    <= bad_d;
            open_q   <= (state_d == ST_OPEN);
            locked_q <= (state_d == ST_LOCKOUT);
            rdy_q    <= (state_d == ST_G0) || (state_d == ST_G1) || (state_d == ST_G2);
        end
    end

    assign entry_rdy_o  = rdy_q;
    assign open_o       = open_q;
    assign locked_out_o = locked_q;
    assign fail_cnt_o   = fail_q;
    assign bad_digit_o  = bad_q;

endmodule
